// File: rtl/bcp_clause_driver.sv
// bcp_clause_driver: clause-store sequencer that feeds bcp_checker1 one clause at a time until fixpoint or conflict.
// Optional checker-handshake watchdog: define BCP_WATCHDOG_EN (adds the wd_err output).
module bcp_clause_driver #(
  parameter int VAR_NUM    = 8,
  parameter int CLAUSE_NUM = 16,
  parameter int CIDX_W     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [VAR_NUM-1:0]  init_assignment,
  input  logic [VAR_NUM-1:0]  init_free,
  input  logic                cl_wr_en,
  input  logic [CIDX_W-1:0]   cl_wr_addr,
  input  logic [VAR_NUM-1:0]  cl_wr_type,
  input  logic [VAR_NUM-1:0]  cl_wr_mask,
  output logic                chk_reset,
  output logic                chk_en,
  output logic [VAR_NUM-1:0]  chk_free,
  output logic [VAR_NUM-1:0]  chk_assignment,
  output logic [VAR_NUM-1:0]  chk_clause_type,
  output logic [VAR_NUM-1:0]  chk_clause_mask,
  output logic [VAR_NUM-1:0]  chk_clause_size,
  output logic [VAR_NUM-1:0]  chk_counter,
  input  logic                chk_unit_exist,
  input  logic [VAR_NUM-1:0]  chk_implication,
  input  logic                chk_bcp_finish,
  output logic [VAR_NUM-1:0]  assignment_out,
  output logic [VAR_NUM-1:0]  free_out,
  output logic                busy,
  output logic                done,
  output logic                conflict,
  output logic [7:0]          impl_count
`ifdef BCP_WATCHDOG_EN
  ,
  output logic                wd_err
`endif
);

  // state | meaning
  // IDLE  | waiting for start, clause store writable
  // PREP  | evaluate entry idx, latch checker operands
  // ISSUE | checker reset visible, enable pulse next
  // WAIT  | operands held until chk_bcp_finish
  // APPLY | write the lowest implied variable back
  // NEXT  | advance idx, or start a new pass if anything changed
  // FIN   | done pulse
  typedef enum logic [2:0] {IDLE, PREP, ISSUE, WAIT, APPLY, NEXT, FIN} state_t;

  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(CLAUSE_NUM - 1);

  function automatic logic [VAR_NUM-1:0] popcount(input logic [VAR_NUM-1:0] v);
    logic [VAR_NUM-1:0] c;
    c = '0;
    for (int i = 0; i < VAR_NUM; i++) c = c + VAR_NUM'(v[i]);
    return c;
  endfunction

  state_t                state_q, state_d;
  logic [CIDX_W-1:0]     idx_q, idx_d;
  logic [CLAUSE_NUM-1:0] valid_q, valid_d;
  logic [VAR_NUM-1:0]    work_asgn_q, work_asgn_d;
  logic [VAR_NUM-1:0]    work_free_q, work_free_d;
  logic                  changed_q, changed_d;
  logic [7:0]            impl_count_q, impl_count_d;
  logic                  conflict_q, conflict_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  chk_reset_q, chk_reset_d;
  logic                  chk_en_q, chk_en_d;
  logic [VAR_NUM-1:0]    op_free_q, op_free_d;
  logic [VAR_NUM-1:0]    op_asgn_q, op_asgn_d;
  logic [VAR_NUM-1:0]    op_type_q, op_type_d;
  logic [VAR_NUM-1:0]    op_mask_q, op_mask_d;
  logic [VAR_NUM-1:0]    op_size_q, op_size_d;
  logic [VAR_NUM-1:0]    op_cnt_q, op_cnt_d;
`ifdef BCP_WATCHDOG_EN
  logic [3:0]            wd_cnt_q, wd_cnt_d;
  logic                  wd_err_q, wd_err_d;
`endif

  logic [VAR_NUM-1:0]    type_mem [CLAUSE_NUM];
  logic [VAR_NUM-1:0]    mask_mem [CLAUSE_NUM];

  logic                  wr_ok;
  logic [VAR_NUM-1:0]    ent_mask, ent_type, ent_fals, ent_size, ent_cnt, impl_lsb;

  assign wr_ok    = cl_wr_en && (state_q == IDLE);
  assign ent_mask = mask_mem[idx_q];
  assign ent_type = type_mem[idx_q];
  assign ent_fals = ent_mask & ~work_free_q & (work_asgn_q ^ ent_type);
  assign ent_size = popcount(ent_mask);
  assign ent_cnt  = popcount(ent_fals);
  // two's-complement trick isolates the lowest set bit of a multi-hot implication
  assign impl_lsb = chk_implication & (~chk_implication + VAR_NUM'(1));

  // Store payload is not reset; only the valid bits are.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      type_mem[cl_wr_addr] <= cl_wr_type;
      mask_mem[cl_wr_addr] <= cl_wr_mask;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    work_asgn_d  = work_asgn_q;
    work_free_d  = work_free_q;
    changed_d    = changed_q;
    impl_count_d = impl_count_q;
    conflict_d   = conflict_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    chk_reset_d  = 1'b0;
    chk_en_d     = 1'b0;
    op_free_d    = op_free_q;
    op_asgn_d    = op_asgn_q;
    op_type_d    = op_type_q;
    op_mask_d    = op_mask_q;
    op_size_d    = op_size_q;
    op_cnt_d     = op_cnt_q;
`ifdef BCP_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
    wd_err_d     = wd_err_q;
`endif
    if (wr_ok) valid_d[cl_wr_addr] = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_asgn_d  = init_assignment;
          work_free_d  = init_free;
          idx_d        = '0;
          changed_d    = 1'b0;
          impl_count_d = 8'd0;
          conflict_d   = 1'b0;
          busy_d       = 1'b1;
`ifdef BCP_WATCHDOG_EN
          wd_err_d     = 1'b0;
`endif
          state_d      = PREP;
        end
      end
      PREP: begin
        if (!valid_q[idx_q] || (ent_mask == '0)) begin
          state_d = NEXT;
        end else if (ent_cnt == ent_size) begin
          conflict_d = 1'b1;
          state_d    = FIN;
        end else begin
          op_free_d   = work_free_q;
          op_asgn_d   = work_asgn_q;
          op_type_d   = ent_type;
          op_mask_d   = ent_mask;
          op_size_d   = ent_size;
          op_cnt_d    = ent_cnt;
          chk_reset_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        chk_en_d = 1'b1;
`ifdef BCP_WATCHDOG_EN
        wd_cnt_d = 4'd15;
`endif
        state_d  = WAIT;
      end
      WAIT: begin
        if (chk_bcp_finish) begin
          state_d = APPLY;
        end
`ifdef BCP_WATCHDOG_EN
        else if (wd_cnt_q == 4'd0) begin
          conflict_d = 1'b1;
          wd_err_d   = 1'b1;
          state_d    = FIN;
        end else begin
          wd_cnt_d = wd_cnt_q - 4'd1;
        end
`endif
      end
      APPLY: begin
        if (chk_unit_exist && ((impl_lsb & work_free_q) != '0)) begin
          work_asgn_d  = (work_asgn_q & ~impl_lsb) | (op_type_q & impl_lsb);
          work_free_d  = work_free_q & ~impl_lsb;
          changed_d    = 1'b1;
          impl_count_d = (impl_count_q == 8'd255) ? 8'd255 : impl_count_q + 8'd1;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + CIDX_W'(1);
          state_d = PREP;
        end else if (changed_q) begin
          changed_d = 1'b0;
          idx_d     = '0;
          state_d   = PREP;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      valid_q      <= '0;
      work_asgn_q  <= '0;
      work_free_q  <= '0;
      changed_q    <= 1'b0;
      impl_count_q <= 8'd0;
      conflict_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      chk_reset_q  <= 1'b0;
      chk_en_q     <= 1'b0;
      op_free_q    <= '0;
      op_asgn_q    <= '0;
      op_type_q    <= '0;
      op_mask_q    <= '0;
      op_size_q    <= '0;
      op_cnt_q     <= '0;
`ifdef BCP_WATCHDOG_EN
      wd_cnt_q     <= 4'd0;
      wd_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      work_asgn_q  <= work_asgn_d;
      work_free_q  <= work_free_d;
      changed_q    <= changed_d;
      impl_count_q <= impl_count_d;
      conflict_q   <= conflict_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      chk_reset_q  <= chk_reset_d;
      chk_en_q     <= chk_en_d;
      op_free_q    <= op_free_d;
      op_asgn_q    <= op_asgn_d;
      op_type_q    <= op_type_d;
      op_mask_q    <= op_mask_d;
      op_size_q    <= op_size_d;
      op_cnt_q     <= op_cnt_d;
`ifdef BCP_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      wd_err_q     <= wd_err_d;
`endif
    end
  end

  assign chk_reset       = chk_reset_q;
  assign chk_en          = chk_en_q;
  assign chk_free        = op_free_q;
  assign chk_assignment  = op_asgn_q;
  assign chk_clause_type = op_type_q;
  assign chk_clause_mask = op_mask_q;
  assign chk_clause_size = op_size_q;
  assign chk_counter     = op_cnt_q;
  assign assignment_out  = work_asgn_q;
  assign free_out        = work_free_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign conflict        = conflict_q;
  assign impl_count      = impl_count_q;
`ifdef BCP_WATCHDOG_EN
  assign wd_err          = wd_err_q;
`endif

endmodule

// File: tb/tb_bcp_clause_driver.sv
// Bench for bcp_clause_driver: behavioural checker responder plus a pass-level BCP reference model.
module tb_bcp_clause_driver;
  localparam int VN = 8;
  localparam int CN = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [VN-1:0] init_assignment = '0;
  logic [VN-1:0] init_free = '0;
  logic          cl_wr_en = 1'b0;
  logic [3:0]    cl_wr_addr = '0;
  logic [VN-1:0] cl_wr_type = '0;
  logic [VN-1:0] cl_wr_mask = '0;
  logic          chk_reset, chk_en;
  logic [VN-1:0] chk_free, chk_assignment, chk_clause_type, chk_clause_mask;
  logic [VN-1:0] chk_clause_size, chk_counter;
  logic          chk_unit_exist;
  logic [VN-1:0] chk_implication;
  logic          chk_bcp_finish;
  logic [VN-1:0] assignment_out, free_out;
  logic          busy, done, conflict;
  logic [7:0]    impl_count;
`ifdef BCP_WATCHDOG_EN
  logic          wd_err;
`endif

  bcp_clause_driver #(.VAR_NUM(VN), .CLAUSE_NUM(CN), .CIDX_W(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .init_assignment(init_assignment), .init_free(init_free),
    .cl_wr_en(cl_wr_en), .cl_wr_addr(cl_wr_addr), .cl_wr_type(cl_wr_type), .cl_wr_mask(cl_wr_mask),
    .chk_reset(chk_reset), .chk_en(chk_en), .chk_free(chk_free), .chk_assignment(chk_assignment),
    .chk_clause_type(chk_clause_type), .chk_clause_mask(chk_clause_mask),
    .chk_clause_size(chk_clause_size), .chk_counter(chk_counter),
    .chk_unit_exist(chk_unit_exist), .chk_implication(chk_implication), .chk_bcp_finish(chk_bcp_finish),
    .assignment_out(assignment_out), .free_out(free_out),
    .busy(busy), .done(done), .conflict(conflict), .impl_count(impl_count)
`ifdef BCP_WATCHDOG_EN
    , .wd_err(wd_err)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  m_mask [CN];
  logic [7:0]  m_type [CN];
  bit          m_valid [CN];
  bit          force_mode = 1'b0;
  logic [7:0]  force_imp = '0;
  bit          hang = 1'b0;
  logic [47:0] issue_log [$];
  logic [47:0] exp_log [$];

  function automatic int pop(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  // Checker behaviour: unit when exactly one literal is not falsified and it is free.
  function automatic logic [8:0] resp(input logic [7:0] a, f, t, m);
    logic [7:0] live;
    if (force_mode) return {1'b1, force_imp};
    live = m & ~(m & ~f & (a ^ t));
    if (pop(live) == 1 && (live & f) != 8'h00) return {1'b1, live};
    return 9'h000;
  endfunction

  initial begin : checker_model
    logic [8:0] r;
    int pend;
    r = '0;
    pend = -1;
    chk_bcp_finish = 1'b0;
    chk_unit_exist = 1'b0;
    chk_implication = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset !== 1'b1 || chk_reset === 1'b1) begin
        chk_bcp_finish = 1'b0;
        chk_unit_exist = 1'b0;
        chk_implication = '0;
        pend = -1;
      end else if (chk_en === 1'b1) begin
        issue_log.push_back({chk_assignment, chk_free, chk_clause_type, chk_clause_mask,
                             chk_clause_size, chk_counter});
        r = resp(chk_assignment, chk_free, chk_clause_type, chk_clause_mask);
        pend = hang ? -1 : int'($urandom_range(0, 3));
      end
      if (pend == 0) begin
        chk_unit_exist = r[8];
        chk_implication = r[7:0];
        chk_bcp_finish = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
    end
  end

  // Pass-level BCP: sweep all clauses, repeat while a pass assigned something.
  task automatic model_run(input logic [7:0] ia, ifr, output logic [7:0] ea, ef,
                           output int ecnt, output bit econf);
    logic [7:0] a, f, fals;
    logic [8:0] r;
    bit fin, changed;
    int v;
    a = ia; f = ifr; ecnt = 0; econf = 1'b0; fin = 1'b0;
    exp_log.delete();
    while (!fin) begin
      changed = 1'b0;
      for (int i = 0; i < CN && !fin; i++) begin
        if (m_valid[i] && m_mask[i] != 8'h00) begin
          fals = m_mask[i] & ~f & (a ^ m_type[i]);
          if (pop(fals) == pop(m_mask[i])) begin
            econf = 1'b1;
            fin = 1'b1;
          end else begin
            exp_log.push_back({a, f, m_type[i], m_mask[i], 8'(pop(m_mask[i])), 8'(pop(fals))});
            r = resp(a, f, m_type[i], m_mask[i]);
            if (r[8] && r[7:0] != 8'h00) begin
              v = 0;
              for (int b = 7; b >= 0; b--) if (r[b]) v = b;
              if (f[v]) begin
                a[v] = m_type[i][v];
                f[v] = 1'b0;
                changed = 1'b1;
                if (ecnt < 255) ecnt++;
              end
            end
          end
        end
      end
      if (!changed) fin = 1'b1;
    end
    ea = a; ef = f;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; start = 1'b0; cl_wr_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < CN; i++) m_valid[i] = 1'b0;
  endtask

  task automatic wr_clause(input logic [3:0] addr, input logic [7:0] t, m);
    @(negedge clock);
    cl_wr_en = 1'b1; cl_wr_addr = addr; cl_wr_type = t; cl_wr_mask = m;
    @(negedge clock);
    cl_wr_en = 1'b0;
    m_valid[addr] = 1'b1; m_type[addr] = t; m_mask[addr] = m;
  endtask

  task automatic do_run(input logic [7:0] ia, ifr, output bit to, output int cyc, output bit bsy);
    issue_log.delete();
    @(negedge clock);
    init_assignment = ia; init_free = ifr; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bsy = busy;
    cyc = 1;
    while (done !== 1'b1 && cyc < 4000) begin
      @(negedge clock);
      cyc++;
    end
    to = (done !== 1'b1);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    vectors++;
    if ({busy, done, conflict} !== 3'b000) begin
      miscompares++; $display("FAIL reset_status: busy/done/conflict %b, expected 000", {busy, done, conflict});
    end
    vectors++;
    if ({assignment_out, free_out, impl_count} !== 24'h0) begin
      miscompares++; $display("FAIL reset_work: %h, expected 000000", {assignment_out, free_out, impl_count});
    end
    vectors++;
    if ({chk_en, chk_reset} !== 2'b00) begin
      miscompares++; $display("FAIL reset_strobes: %b, expected 00", {chk_en, chk_reset});
    end
    vectors++;
    if ({chk_free, chk_assignment, chk_clause_type, chk_clause_mask, chk_clause_size, chk_counter} !== 48'h0) begin
      miscompares++; $display("FAIL reset_operands: %h, expected 0", {chk_free, chk_assignment, chk_clause_type, chk_clause_mask});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < CN; i++) m_valid[i] = 1'b0;
  endtask

  task automatic test_unit_prop();
    bit to, bsy; int cyc;
    apply_reset();
    force_mode = 1'b0;
    wr_clause(4'd0, 8'h07, 8'h07);
    do_run(8'h00, 8'h04, to, cyc, bsy);
    vectors++;
    if (bsy !== 1'b1) begin miscompares++; $display("FAIL unit_busy: busy %b after start, expected 1", bsy); end
    vectors++;
    if (to) begin miscompares++; $display("FAIL unit_done: no done in %0d cycles, expected done", cyc); end
    vectors++;
    if (assignment_out !== 8'h04) begin miscompares++; $display("FAIL unit_asgn: %h, expected 04", assignment_out); end
    vectors++;
    if (free_out !== 8'h00) begin miscompares++; $display("FAIL unit_free: %h, expected 00", free_out); end
    vectors++;
    if (impl_count !== 8'd1) begin miscompares++; $display("FAIL unit_count: %0d, expected 1", impl_count); end
    vectors++;
    if (conflict !== 1'b0) begin miscompares++; $display("FAIL unit_conflict: %b, expected 0", conflict); end
    vectors++;
    if (issue_log.size() != 2) begin miscompares++; $display("FAIL unit_issues: %0d, expected 2", issue_log.size()); end
    @(negedge clock);
    vectors++;
    if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL unit_pulse: done/busy %b, expected 00", {done, busy}); end
  endtask

  task automatic test_chain_fixpoint();
    bit to, bsy; int cyc;
    apply_reset();
    wr_clause(4'd0, 8'h03, 8'h03);
    wr_clause(4'd1, 8'h04, 8'h06);
    do_run(8'h00, 8'h03, to, cyc, bsy);
    vectors++;
    if (to) begin miscompares++; $display("FAIL chain_done: no done in %0d cycles, expected done", cyc); end
    vectors++;
    if ({assignment_out, free_out} !== 16'h0100) begin
      miscompares++; $display("FAIL chain_vec: %h, expected 0100", {assignment_out, free_out});
    end
    vectors++;
    if (impl_count !== 8'd2) begin miscompares++; $display("FAIL chain_count: %0d, expected 2", impl_count); end
    vectors++;
    if (conflict !== 1'b0) begin miscompares++; $display("FAIL chain_conflict: %b, expected 0", conflict); end
    vectors++;
    if (issue_log.size() != 6) begin miscompares++; $display("FAIL chain_issues: %0d, expected 6 (3 passes)", issue_log.size()); end
  endtask

  task automatic test_conflict();
    bit to, bsy; int cyc;
    apply_reset();
    wr_clause(4'd0, 8'h03, 8'h03);
    do_run(8'h00, 8'h00, to, cyc, bsy);
    vectors++;
    if (to || cyc > 3) begin miscompares++; $display("FAIL conf_latency: done after %0d cycles, expected <= 3", cyc); end
    vectors++;
    if (conflict !== 1'b1) begin miscompares++; $display("FAIL conf_flag: %b, expected 1", conflict); end
    vectors++;
    if (issue_log.size() != 0) begin miscompares++; $display("FAIL conf_issues: %0d, expected 0", issue_log.size()); end
    vectors++;
    if (impl_count !== 8'd0) begin miscompares++; $display("FAIL conf_count: %0d, expected 0", impl_count); end
    repeat (3) @(negedge clock);
    vectors++;
    if (conflict !== 1'b1) begin miscompares++; $display("FAIL conf_hold: %b, expected 1", conflict); end
  endtask

  task automatic test_skip_ignore();
    bit to, bsy; int cyc;
    apply_reset();
    wr_clause(4'd3, 8'hFF, 8'h00);
    wr_clause(4'd5, 8'h30, 8'h30);
    force_mode = 1'b1; force_imp = 8'h30;
    do_run(8'h00, 8'h30, to, cyc, bsy);
    force_mode = 1'b0;
    vectors++;
    if (to) begin miscompares++; $display("FAIL skip_done: no done in %0d cycles, expected done", cyc); end
    vectors++;
    if ({assignment_out, free_out} !== 16'h1020) begin
      miscompares++; $display("FAIL skip_vec: %h, expected 1020", {assignment_out, free_out});
    end
    vectors++;
    if (impl_count !== 8'd1) begin miscompares++; $display("FAIL skip_count: %0d, expected 1", impl_count); end
    vectors++;
    if (issue_log.size() != 2) begin miscompares++; $display("FAIL skip_issues: %0d, expected 2", issue_log.size()); end
    vectors++;
    if (issue_log.size() > 0 && issue_log[0][23:16] !== 8'h30) begin
      miscompares++; $display("FAIL skip_mask: issued mask %h, expected 30", issue_log[0][23:16]);
    end
  endtask

  task automatic test_busy_ignore();
    bit to, bsy; int cyc;
    apply_reset();
    wr_clause(4'd0, 8'h07, 8'h07);
    fork
      do_run(8'h00, 8'h04, to, cyc, bsy);
      begin
        repeat (3) @(negedge clock);
        init_assignment = 8'hFF; init_free = 8'h00; start = 1'b1;
        cl_wr_en = 1'b1; cl_wr_addr = 4'd1; cl_wr_type = 8'h03; cl_wr_mask = 8'h03;
        @(negedge clock);
        start = 1'b0; cl_wr_en = 1'b0;
      end
    join
    vectors++;
    if (to) begin miscompares++; $display("FAIL busy_done: no done in %0d cycles, expected done", cyc); end
    vectors++;
    if ({assignment_out, free_out, impl_count} !== 24'h040001) begin
      miscompares++; $display("FAIL busy_result: %h, expected 040001", {assignment_out, free_out, impl_count});
    end
    vectors++;
    if (conflict !== 1'b0) begin miscompares++; $display("FAIL busy_conflict: %b, expected 0", conflict); end
    do_run(8'h00, 8'h04, to, cyc, bsy);
    vectors++;
    if (to || conflict !== 1'b0) begin miscompares++; $display("FAIL busy_write: conflict %b, expected 0", conflict); end
    vectors++;
    if (issue_log.size() != 2) begin miscompares++; $display("FAIL busy_issues: %0d, expected 2", issue_log.size()); end
  endtask

  task automatic test_reset_mid_wait();
    bit to, bsy; int cyc;
    apply_reset();
    hang = 1'b1;
    wr_clause(4'd0, 8'h07, 8'h07);
    @(negedge clock);
    init_assignment = 8'h00; init_free = 8'h04; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (chk_en !== 1'b1 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    vectors++;
    if (chk_en !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL midrst_issue: chk_en/busy %b, expected 11", {chk_en, busy});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({chk_en, chk_reset, busy, done, conflict, assignment_out, free_out, impl_count} !== 29'h0) begin
      miscompares++;
      $display("FAIL midrst_clear: %h, expected 0",
               {chk_en, chk_reset, busy, done, conflict, assignment_out, free_out, impl_count});
    end
    @(negedge clock);
    reset = 1'b1;
    hang = 1'b0;
    for (int i = 0; i < CN; i++) m_valid[i] = 1'b0;
    do_run(8'h5A, 8'h0F, to, cyc, bsy);
    vectors++;
    if (to) begin miscompares++; $display("FAIL empty_done: no done in %0d cycles, expected done", cyc); end
    vectors++;
    if ({assignment_out, free_out, impl_count} !== 24'h5A0F00) begin
      miscompares++; $display("FAIL empty_result: %h, expected 5a0f00", {assignment_out, free_out, impl_count});
    end
    vectors++;
    if (issue_log.size() != 0 || conflict !== 1'b0) begin
      miscompares++; $display("FAIL empty_issues: %0d issued conflict %b, expected 0 and 0", issue_log.size(), conflict);
    end
  endtask

`ifdef BCP_WATCHDOG_EN
  task automatic test_watchdog();
    bit to, bsy; int cyc;
    apply_reset();
    hang = 1'b1;
    wr_clause(4'd0, 8'h07, 8'h07);
    do_run(8'h00, 8'h04, to, cyc, bsy);
    hang = 1'b0;
    vectors++;
    if (to || cyc != 20) begin miscompares++; $display("FAIL wd_latency: done after %0d cycles, expected 20", cyc); end
    vectors++;
    if ({wd_err, conflict} !== 2'b11) begin miscompares++; $display("FAIL wd_flags: %b, expected 11", {wd_err, conflict}); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [7:0] ia, ifr, ea, ef;
      int ecnt, cyc, k, nw;
      bit econf, to, bsy;
      apply_reset();
      force_mode = ($urandom_range(0, 3) == 0);
      force_imp = 8'($urandom);
      nw = int'($urandom_range(1, 8));
      for (int j = 0; j < nw; j++)
        wr_clause(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom) & 8'($urandom));
      ia = 8'($urandom);
      ifr = 8'($urandom);
      model_run(ia, ifr, ea, ef, ecnt, econf);
      do_run(ia, ifr, to, cyc, bsy);
      vectors++;
      if (to) begin miscompares++; $display("FAIL rand%0d_done: no done in %0d cycles", n, cyc); end
      vectors++;
      if (assignment_out !== ea) begin miscompares++; $display("FAIL rand%0d_asgn: %h, expected %h", n, assignment_out, ea); end
      vectors++;
      if (free_out !== ef) begin miscompares++; $display("FAIL rand%0d_free: %h, expected %h", n, free_out, ef); end
      vectors++;
      if (impl_count !== 8'(ecnt)) begin miscompares++; $display("FAIL rand%0d_count: %0d, expected %0d", n, impl_count, ecnt); end
      vectors++;
      if (conflict !== econf) begin miscompares++; $display("FAIL rand%0d_conflict: %b, expected %b", n, conflict, econf); end
      vectors++;
      if (issue_log.size() != exp_log.size()) begin
        miscompares++; $display("FAIL rand%0d_issues: %0d, expected %0d", n, issue_log.size(), exp_log.size());
      end else begin
        k = -1;
        foreach (exp_log[i]) if (k < 0 && issue_log[i] !== exp_log[i]) k = i;
        if (k >= 0) begin
          miscompares++; $display("FAIL rand%0d_operands[%0d]: %h, expected %h", n, k, issue_log[k], exp_log[k]);
        end
      end
    end
    force_mode = 1'b0;
  endtask

  initial begin : main
    test_reset();
    test_unit_prop();
    test_chain_fixpoint();
    test_conflict();
    test_skip_ignore();
    test_busy_ignore();
    test_reset_mid_wait();
`ifdef BCP_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
